// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM state encodings
// and requester port indices.
package arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic P_LSU = 1'b0;
  localparam logic P_AUX = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
// Ports: req[1:0] pending requests, last = previous winner; valid, idx = winner.
module rr_pick2
  import arb_defs::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  assign valid = |req;

  always_comb begin
    idx = P_LSU;
    unique case (1'b1)
      (req == 2'b11): idx = ~last;
      (req == 2'b10): idx = P_AUX;
      default:        idx = P_LSU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between two requesters (r0 = LSU,
// r1 = aux master). Ports: clk, rst (sync, active high), r{0,1}_req/we/addr/
// wdata in, r{0,1}_ack/rdata out, mem_read/write/addr/wdata out, mem_rdata in.
module mem_arbiter
  import arb_defs::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                last_gnt;
  logic                gnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic                pick_valid;
  logic                pick_idx;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  rr_pick2 u_pick (
    .req   ({r1_req, r0_req}),
    .last  (last_gnt),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign win_we    = pick_idx ? r1_we    : r0_we;
  assign win_addr  = pick_idx ? r1_addr  : r0_addr;
  assign win_wdata = pick_idx ? r1_wdata : r0_wdata;

  // The RAM bus simply shows the latched attributes; they only change
  // on a new grant, so they never toggle between transactions.
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_gnt  <= P_AUX;
      gnt       <= P_LSU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt       <= pick_idx;
            lat_we    <= win_we;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            cnt       <= CNT_INIT;
            // Strobes are registered so they line up with ACCESS.
            mem_read  <= ~win_we;
            mem_write <= win_we;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_write <= 1'b0;
          if (cnt == 4'd0) begin
            mem_read <= 1'b0;
            if (!lat_we) begin
              if (gnt == P_AUX) r1_rdata <= mem_rdata;
              else              r0_rdata <= mem_rdata;
            end
            if (gnt == P_AUX) r1_ack <= 1'b1;
            else              r0_ack <= 1'b1;
            last_gnt <= gnt;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 has LATENCY=1, instance 1 LATENCY=3.
// A transaction-level model is compared against the DUT every cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b1;
  logic        req  [2][2];
  logic        we   [2][2];
  logic [31:0] addr [2][2];
  logic [31:0] wdata[2][2];
  logic [31:0] rdata[2][2];
  logic        ack  [2][2];
  logic        mread [2];
  logic        mwrite[2];
  logic [31:0] maddr [2];
  logic [31:0] mwdata[2];
  logic [31:0] mrdata[2];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ival(input int a);
    if (a == 16) return 32'hDEADBEEF;
    return {8'(a), 8'(a ^ 8'h5A), 8'hC3, 8'(~a)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [31:0] ram [256];
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(g == 0 ? 1 : 3)) u (
      .clk(clk), .rst(rst),
      .r0_req(req[g][0]), .r0_we(we[g][0]), .r0_addr(addr[g][0]),
      .r0_wdata(wdata[g][0]), .r0_ack(ack[g][0]), .r0_rdata(rdata[g][0]),
      .r1_req(req[g][1]), .r1_we(we[g][1]), .r1_addr(addr[g][1]),
      .r1_wdata(wdata[g][1]), .r1_ack(ack[g][1]), .r1_rdata(rdata[g][1]),
      .mem_read(mread[g]), .mem_write(mwrite[g]), .mem_addr(maddr[g]),
      .mem_wdata(mwdata[g]), .mem_rdata(mrdata[g])
    );
    assign mrdata[g] = ram[maddr[g][7:0]];
    always @(posedge clk) begin
      if (load) begin
        for (int a = 0; a < 256; a++) ram[a] <= ival(a);
      end else if (mwrite[g]) begin
        ram[maddr[g][7:0]] <= mwdata[g];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---- transaction-level model ----
  bit          armed = 0;
  bit          busy [2];
  int          k    [2];
  int          mg   [2];
  int          mlast[2];
  logic        mwe  [2];
  logic [31:0] ma   [2];
  logic [31:0] mw   [2];
  logic [31:0] xr   [2][2];
  logic [31:0] mm   [2][256];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_step(input int i);
    int L;
    int w;
    L = lat_of(i);
    if (rst) begin
      busy[i] = 0; k[i] = 0; mg[i] = 0; mlast[i] = 1;
      mwe[i] = 0; ma[i] = 0; mw[i] = 0; xr[i][0] = 0; xr[i][1] = 0;
      if (load) for (int a = 0; a < 256; a++) mm[i][a] = ival(a);
      armed = 1;
    end else if (busy[i]) begin
      if (k[i] == 1 && mwe[i]) mm[i][ma[i][7:0]] = mw[i];
      if (k[i] == L) begin
        if (!mwe[i]) xr[i][mg[i]] = mm[i][ma[i][7:0]];
        mlast[i] = mg[i];
      end
      if (k[i] == L + 1) busy[i] = 0;
      else k[i]++;
    end else if (req[i][0] || req[i][1]) begin
      if (req[i][0] && req[i][1]) w = (mlast[i] == 1) ? 0 : 1;
      else w = req[i][1] ? 1 : 0;
      busy[i] = 1; k[i] = 1; mg[i] = w;
      mwe[i] = we[i][w]; ma[i] = addr[i][w]; mw[i] = wdata[i][w];
    end
  endtask

  int rd_cnt[2];
  int wr_cnt[2];
  int ack_cnt[2][2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rd_cnt[i] = 0; wr_cnt[i] = 0; ack_cnt[i][0] = 0; ack_cnt[i][1] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_step(i);
      #1;
      if (armed) begin
        for (int i = 0; i < 2; i++) begin
          int L;
          L = lat_of(i);
          chk($sformatf("i%0d mem_read", i), 32'(mread[i]),
              32'(busy[i] && k[i] <= L && !mwe[i]));
          chk($sformatf("i%0d mem_write", i), 32'(mwrite[i]),
              32'(busy[i] && k[i] == 1 && mwe[i]));
          chk($sformatf("i%0d mem_addr", i), maddr[i], ma[i]);
          chk($sformatf("i%0d mem_wdata", i), mwdata[i], mw[i]);
          for (int p = 0; p < 2; p++) begin
            chk($sformatf("i%0d r%0d_ack", i, p), 32'(ack[i][p]),
                32'(busy[i] && k[i] == L + 1 && mg[i] == p));
            chk($sformatf("i%0d r%0d_rdata", i, p), rdata[i][p], xr[i][p]);
            if (ack[i][p]) ack_cnt[i][p]++;
          end
          if (mread[i]) rd_cnt[i]++;
          if (mwrite[i]) wr_cnt[i]++;
        end
      end
    end
  end

  // ---- directed helpers ----
  task automatic go(input int i, input int p, input logic w,
                    input logic [31:0] a, input logic [31:0] d, output int lat);
    int t0;
    bit got;
    @(negedge clk);
    req[i][p] = 1; we[i][p] = w; addr[i][p] = a; wdata[i][p] = d;
    t0 = cyc;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk); #2;
      if (ack[i][p]) got = 1;
    end
    lat = got ? cyc - t0 : -1;
    if (!got) chk($sformatf("i%0d r%0d ack timeout", i, p), 0, 1);
    @(negedge clk);
    req[i][p] = 0;
  endtask

  task automatic do_reset(input bit ld);
    @(negedge clk);
    rst = 1; load = ld;
    repeat (2) @(negedge clk);
    rst = 0; load = 0;
  endtask

  task automatic rnd_attr(input int i, input int p);
    we[i][p] = 1'($urandom);
    addr[i][p] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 15);
    wdata[i][p] = $urandom;
  endtask

  initial begin
    int lat, r0, w0, a0, a1, t0, nack;
    int order[$];
    int acyc[$];
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 0; we[i][p] = 0; addr[i][p] = 0; wdata[i][p] = 0;
      end

    do_reset(1);
    @(posedge clk); #2;
    chk("reset r0_rdata", rdata[0][0], 32'h0);
    chk("reset mem_read", 32'(mread[0]), 32'h0);

    // single read, both latencies
    for (int i = 0; i < 2; i++) begin
      r0 = rd_cnt[i]; a1 = ack_cnt[i][1];
      go(i, 0, 0, 32'h10, 32'h0, lat);
      chk($sformatf("i%0d read latency", i), 32'(lat), 32'(lat_of(i) + 1));
      chk($sformatf("i%0d read data", i), rdata[i][0], 32'hDEADBEEF);
      chk($sformatf("i%0d read strobes", i), 32'(rd_cnt[i] - r0), 32'(lat_of(i)));
      chk($sformatf("i%0d r1 no ack", i), 32'(ack_cnt[i][1] - a1), 32'h0);
    end

    // write then read-back on r1
    do_reset(0);
    for (int i = 0; i < 2; i++) begin
      w0 = wr_cnt[i];
      go(i, 1, 1, 32'h20, 32'h12345678, lat);
      chk($sformatf("i%0d write strobes", i), 32'(wr_cnt[i] - w0), 32'h1);
      chk($sformatf("i%0d write latency", i), 32'(lat), 32'(lat_of(i) + 1));
      go(i, 1, 0, 32'h20, 32'h0, lat);
      chk($sformatf("i%0d readback", i), rdata[i][1], 32'h12345678);
      chk($sformatf("i%0d r0_rdata kept", i), rdata[i][0], 32'h0);
    end

    // contention after reset: strict alternation, 3-cycle period
    do_reset(0);
    @(negedge clk);
    req[0][0] = 1; we[0][0] = 0; addr[0][0] = 32'h3;
    req[0][1] = 1; we[0][1] = 0; addr[0][1] = 32'h4;
    t0 = cyc;
    for (int n = 0; n < 40 && order.size() < 4; n++) begin
      @(posedge clk); #2;
      for (int p = 0; p < 2; p++)
        if (ack[0][p]) begin order.push_back(p); acyc.push_back(cyc); end
    end
    @(negedge clk);
    req[0][0] = 0; req[0][1] = 0;
    chk("contention acks", 32'(order.size()), 32'h4);
    if (order.size() == 4) begin
      chk("first ack cycle", 32'(acyc[0] - t0), 32'h2);
      for (int n = 0; n < 4; n++) chk("grant order", 32'(order[n]), 32'(n % 2));
      for (int n = 1; n < 4; n++) chk("grant period", 32'(acyc[n] - acyc[n-1]), 32'h3);
    end
    repeat (4) @(negedge clk);

    // reset in second ACCESS cycle, LATENCY=3
    @(negedge clk);
    req[1][0] = 1; we[1][0] = 0; addr[1][0] = 32'h30;
    t0 = cyc;
    while (cyc < t0 + 2) @(negedge clk);
    a0 = ack_cnt[1][0];
    rst = 1;
    @(negedge clk);
    rst = 0; req[1][0] = 0;
    chk("reset aborts read", 32'(mread[1]), 32'h0);
    repeat (10) @(negedge clk);
    chk("no ack after abort", 32'(ack_cnt[1][0] - a0), 32'h0);
    req[1][0] = 1; req[1][1] = 1; we[1][1] = 0; addr[1][1] = 32'h31;
    nack = -1;
    for (int n = 0; n < 40 && nack < 0; n++) begin
      @(posedge clk); #2;
      if (ack[1][0]) nack = 0;
      else if (ack[1][1]) nack = 1;
    end
    @(negedge clk);
    req[1][0] = 0; req[1][1] = 0;
    chk("post-reset winner", 32'(nack), 32'h0);
    repeat (8) @(negedge clk);

    // r0 drops req and changes addr mid-ACCESS
    a0 = ack_cnt[0][0];
    req[0][0] = 1; we[0][0] = 0; addr[0][0] = 32'h40;
    @(negedge clk);
    req[0][0] = 0; addr[0][0] = 32'h99;
    chk("latched addr", maddr[0], 32'h40);
    repeat (8) @(negedge clk);
    chk("single ack on drop", 32'(ack_cnt[0][0] - a0), 32'h1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) begin
          if (req[i][p] && ack[i][p]) begin
            if ($urandom_range(0, 1) == 0) req[i][p] = 0;
            else rnd_attr(i, p);
          end else if (!req[i][p]) begin
            if ($urandom_range(0, 2) == 0) begin req[i][p] = 1; rnd_attr(i, p); end
          end else if ($urandom_range(0, 15) == 0) begin
            addr[i][p] = $urandom;
          end else if ($urandom_range(0, 199) == 0) begin
            req[i][p] = 0;
          end
        end
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 2; i++) begin req[i][0] = 0; req[i][1] = 0; end
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
